// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction/flag inputs and decoded strobes.
interface multicycle_control_if #(
  parameter int OPCODE_W = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic [OPCODE_W-1:0] alu_op;
  logic                next_ins;
  logic                immediate;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                branch_taken;

  modport master (
    input  opcode, zero, mem_ready,
    output alu_op, next_ins, immediate, reg_write, mem_read, mem_write,
           mem_to_reg, branch_taken
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  alu_op, next_ins, immediate, reg_write, mem_read, mem_write,
           mem_to_reg, branch_taken
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/MEM/WRITEBACK controller with MEM timeout and retire counter.
// CTRL_SKIP_MEM_EN: non-LD/ST opcodes bypass the MEM state.
module multicycle_control #(
  parameter int OPCODE_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  multicycle_control_if.master  bus,
  output logic [2:0]            state,
  output logic                  halted,
  output logic [CNT_W-1:0]      retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

`ifdef CTRL_SKIP_MEM_EN
  localparam bit SKIP_MEM = 1'b1;
`else
  localparam bit SKIP_MEM = 1'b0;
`endif

  localparam logic [2:0] OP_MOV = 3'd4;
  localparam logic [2:0] OP_LD  = 3'd5;
  localparam logic [2:0] OP_ST  = 3'd6;
  localparam logic [2:0] OP_BRZ = 3'd7;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    MEM       = 3'd2,
    WRITEBACK = 3'd3,
    HALT      = 3'd4
  } state_t;

  state_t              stateQ, stateD;
  logic [OPCODE_W-1:0] ir;
  logic                zeroQ;
  logic [WAIT_W-1:0]   waitCnt;
  logic [CNT_W-1:0]    retiredQ;

  logic [2:0] irOp;
  logic       irIllegal;
  logic       irIsMem;

  // Any bit above the 3-bit opcode field marks the instruction illegal.
  assign irOp      = ir[2:0];
  assign irIllegal = (ir >> 3) != '0;
  assign irIsMem   = (irOp == OP_LD) || (irOp == OP_ST);

  logic fetchStb, immStb, regWrStb, memRdStb, memWrStb, memToRegStb, branchStb;

  always_comb begin
    stateD      = stateQ;
    fetchStb    = 1'b0;
    immStb      = 1'b0;
    regWrStb    = 1'b0;
    memRdStb    = 1'b0;
    memWrStb    = 1'b0;
    memToRegStb = 1'b0;
    branchStb   = 1'b0;
    case (stateQ)
      FETCH: begin
        fetchStb = 1'b1;
        stateD   = DECODE;
      end
      DECODE: begin
        immStb = !irIllegal && (irOp == OP_MOV);
        if (irIllegal)
          stateD = HALT;
        else if (SKIP_MEM && !irIsMem)
          stateD = WRITEBACK;
        else
          stateD = MEM;
      end
      MEM: begin
        // Non-memory ops pass through in one cycle without watching mem_ready.
        if (irIsMem) begin
          memRdStb = (irOp == OP_LD);
          memWrStb = (irOp == OP_ST);
          if (bus.mem_ready)
            stateD = WRITEBACK;
          else if (waitCnt == WAIT_LAST)
            stateD = HALT;
        end else begin
          stateD = WRITEBACK;
        end
      end
      WRITEBACK: begin
        regWrStb    = (irOp <= OP_LD);
        memToRegStb = (irOp == OP_LD);
        branchStb   = (irOp == OP_BRZ) && zeroQ;
        stateD      = FETCH;
      end
      HALT:    stateD = HALT;
      default: stateD = HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stateQ   <= FETCH;
      ir       <= '0;
      zeroQ    <= 1'b0;
      waitCnt  <= '0;
      retiredQ <= '0;
    end else begin
      stateQ <= stateD;
      if (stateQ == FETCH)
        ir <= bus.opcode;
      if (stateQ == DECODE)
        zeroQ <= bus.zero;
      // DECODE is the only way into MEM, so clearing here clears on entry.
      if (stateQ == DECODE)
        waitCnt <= '0;
      else if (stateQ == MEM && irIsMem && !bus.mem_ready)
        waitCnt <= waitCnt + 1'b1;
      if (stateQ == WRITEBACK)
        retiredQ <= retiredQ + 1'b1;
    end
  end

  // next_ins is gated by reset_n so it drops the instant reset asserts.
  assign bus.next_ins     = fetchStb & reset_n;
  assign bus.immediate    = immStb;
  assign bus.reg_write    = regWrStb;
  assign bus.mem_read     = memRdStb;
  assign bus.mem_write    = memWrStb;
  assign bus.mem_to_reg   = memToRegStb;
  assign bus.branch_taken = branchStb;
  assign bus.alu_op       = ir;

  assign state   = stateQ;
  assign halted  = (stateQ == HALT);
  assign retired = retiredQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (OPCODE_W=4, CNT_W=4 so the retire counter wraps quickly).
module tb_multicycle_control;

`ifdef CTRL_SKIP_MEM_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] NI   = 7'b1000000;
  localparam logic [6:0] IM   = 7'b0100000;
  localparam logic [6:0] RW   = 7'b0010000;
  localparam logic [6:0] MR   = 7'b0001000;
  localparam logic [6:0] MW   = 7'b0000100;
  localparam logic [6:0] M2R  = 7'b0000010;
  localparam logic [6:0] BT   = 7'b0000001;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] state;
  logic       halted;
  logic [3:0] retired;
  logic [3:0] expRet;
  int         nVec = 0;
  int         nErr = 0;

  always #5 clock = ~clock;

  multicycle_control_if #(.OPCODE_W(4)) bus ();

  multicycle_control #(
    .OPCODE_W(4), .MEM_TIMEOUT(15), .CNT_W(4)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus),
    .state  (state),
    .halted (halted),
    .retired(retired)
  );

  function automatic logic [10:0] outs();
    return {halted, state, bus.next_ins, bus.immediate, bus.reg_write, bus.mem_read,
            bus.mem_write, bus.mem_to_reg, bus.branch_taken};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expOut(input string tag, input logic [2:0] st, input logic [6:0] stb);
    chk(tag, 32'(outs()), 32'({(st == 3'd4), st, stb}));
  endtask

  // Sample and drive just after the falling edge, well away from the rising edge.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic zd,
                       input logic [6:0] decStb, input logic [6:0] wbStb);
    bus.opcode = op;
    expOut({tag, " fetch"}, 3'd0, NI);
    step();
    bus.opcode = 4'hF;
    bus.zero   = zd;
    chk({tag, " alu_op"}, 32'(bus.alu_op), 32'(op));
    expOut({tag, " decode"}, 3'd1, decStb);
    step();
    bus.zero      = ~zd;
    bus.mem_ready = 1'b0;
    if (!SKIP) begin
      expOut({tag, " mem"}, 3'd2, NONE);
      step();
    end
    expOut({tag, " wb"}, 3'd3, wbStb);
    step();
    expRet = expRet + 4'd1;
    chk({tag, " retired"}, 32'(retired), 32'(expRet));
  endtask

  task automatic runMem(input string tag, input bit isLd, input int nWait);
    bus.opcode = isLd ? 4'd5 : 4'd6;
    expOut({tag, " fetch"}, 3'd0, NI);
    step();
    bus.opcode    = 4'hF;
    bus.mem_ready = 1'b0;
    expOut({tag, " decode"}, 3'd1, NONE);
    step();
    for (int i = 0; i < nWait; i++) begin
      expOut({tag, " mem wait"}, 3'd2, isLd ? MR : MW);
      step();
    end
    bus.mem_ready = 1'b1;
    expOut({tag, " mem ready"}, 3'd2, isLd ? MR : MW);
    step();
    bus.mem_ready = 1'b0;
    expOut({tag, " wb"}, 3'd3, isLd ? (RW | M2R) : NONE);
    step();
    expRet = expRet + 4'd1;
    chk({tag, " retired"}, 32'(retired), 32'(expRet));
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.opcode    = 4'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    expRet        = 4'd0;
    repeat (2) step();

    expOut("reset outs", 3'd0, NONE);
    chk("reset retired", 32'(retired), 32'd0);
    chk("reset alu_op", 32'(bus.alu_op), 32'd0);

    reset_n = 1'b1;
    #1;
    runOp("ADD", 4'd0, 1'b0, NONE, RW);
    runOp("XOR", 4'd1, 1'b1, NONE, RW);
    runOp("AND", 4'd2, 1'b0, NONE, RW);
    runOp("RSL", 4'd3, 1'b0, NONE, RW);
    runOp("MOV", 4'd4, 1'b0, IM, RW);
    runMem("LD w3", 1'b1, 3);
    runMem("LD w0", 1'b1, 0);
    runMem("ST w2", 1'b0, 2);
    runOp("BRZ z1", 4'd7, 1'b1, NONE, BT);
    runOp("BRZ z0", 4'd7, 1'b0, NONE, NONE);

    // Ten retired so far; six more wrap the 4-bit counter to zero.
    repeat (6) runOp("ADD wrap", 4'd0, 1'b0, NONE, RW);
    chk("retired wrap", 32'(retired), 32'd0);

    // Reset pulse while an LD waits in MEM.
    bus.opcode = 4'd5;
    step();
    bus.opcode = 4'hF;
    step();
    step();
    step();
    expOut("ld waiting", 3'd2, MR);
    reset_n = 1'b0;
    #1;
    expOut("reset in mem", 3'd0, NONE);
    step();
    expOut("reset held", 3'd0, NONE);
    chk("reset held retired", 32'(retired), 32'd0);
    reset_n = 1'b1;
    #1;
    expRet = 4'd0;
    runOp("ADD post", 4'd0, 1'b0, NONE, RW);

    // ST that never completes: 15 write cycles, then HALT.
    bus.opcode = 4'd6;
    step();
    bus.opcode    = 4'hF;
    bus.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 15; i++) begin
      expOut("st timeout wait", 3'd2, MW);
      step();
    end
    expOut("st timeout halt", 3'd4, NONE);
    chk("halt retired", 32'(retired), 32'd1);
    bus.mem_ready = 1'b1;
    bus.opcode    = 4'd0;
    step();
    step();
    expOut("halt sticky", 3'd4, NONE);
    chk("halt retired frozen", 32'(retired), 32'd1);

    // Illegal opcode (bit 3 set) halts straight out of DECODE.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    bus.opcode = 4'b1000;
    expOut("illegal fetch", 3'd0, NI);
    step();
    bus.opcode = 4'd0;
    expOut("illegal decode", 3'd1, NONE);
    chk("illegal alu_op", 32'(bus.alu_op), 32'h8);
    step();
    expOut("illegal halt", 3'd4, NONE);
    step();
    expOut("illegal halt sticky", 3'd4, NONE);
    chk("illegal alu_op held", 32'(bus.alu_op), 32'h8);
    chk("illegal retired", 32'(retired), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, nErr %0d required 0", nErr);
    $fatal(1, "watchdog");
  end

endmodule
